// File: rtl/fir_mac_seq_if.sv
// fir_mac_seq_if: streaming, flush and coefficient-write signals of fir_mac_seq
interface fir_mac_seq_if #(
  parameter int DATA_W = 17,
  parameter int COEF_W = 17,
  parameter int TAPS   = 4,
  parameter int OUT_W  = 36
);
  localparam int KW = $clog2(TAPS);
  logic [DATA_W-1:0] x_in;
  logic              in_data_vld;
  logic              in_ready;
  logic              flush;
  logic              coef_wr;
  logic [KW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_wdata;
  logic [OUT_W-1:0]  y_out;
  logic              out_data_vld;
  logic              out_ready;
  modport master (
    output x_in, in_data_vld, flush, coef_wr, coef_addr, coef_wdata, out_ready,
    input  in_ready, y_out, out_data_vld
  );
  modport slave (
    input  x_in, in_data_vld, flush, coef_wr, coef_addr, coef_wdata, out_ready,
    output in_ready, y_out, out_data_vld
  );
endinterface

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: time-multiplexed FIR, one signed MAC stepping over TAPS coefficients per sample; define FIR_SAT_EN to saturate y_out when OUT_W < ACC_W
module fir_mac_seq #(
  parameter int DATA_W = 17,
  parameter int COEF_W = 17,
  parameter int TAPS   = 4,
  parameter int OUT_W  = 36
) (
  input logic clk,
  input logic reset,
  fir_mac_seq_if.slave bus
);
  localparam int KW    = $clog2(TAPS);
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = PW + KW;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t                   state;
  logic signed [DATA_W-1:0] x [TAPS];
  logic signed [COEF_W-1:0] c [TAPS];
  logic signed [ACC_W-1:0]  acc, acc_next;
  logic signed [PW-1:0]     prod;
  logic signed [OUT_W-1:0]  y, y_conv;
  logic [KW-1:0]            k;
  logic                     in_ready, out_vld;
  assign prod     = PW'(x[k]) * PW'(c[k]);
  assign acc_next = acc + ACC_W'(prod);
  if (OUT_W >= ACC_W) begin : g_ext
    assign y_conv = OUT_W'(acc_next);
  end else begin : g_narrow
`ifdef FIR_SAT_EN
    logic [ACC_W-OUT_W:0] hi;
    assign hi     = acc_next[ACC_W-1:OUT_W-1];
    assign y_conv = (&hi || ~|hi) ? acc_next[OUT_W-1:0]
                                  : {acc_next[ACC_W-1], {(OUT_W-1){~acc_next[ACC_W-1]}}};
`else
    assign y_conv = acc_next[OUT_W-1:0];
`endif
  end
  assign bus.in_ready     = in_ready;
  assign bus.out_data_vld = out_vld;
  assign bus.y_out        = y;
  // control FSM, delay line, coefficient bank and MAC accumulator
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      out_vld  <= 1'b0;
      y        <= '0;
      acc      <= '0;
      k        <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x[i] <= '0;
        c[i] <= '0;
      end
    end else begin
      if (bus.coef_wr && 32'(bus.coef_addr) < TAPS)
        c[bus.coef_addr] <= bus.coef_wdata;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (bus.flush)
            for (int i = 0; i < TAPS; i++) x[i] <= '0;
          if (bus.in_data_vld && in_ready) begin
            for (int i = 1; i < TAPS; i++) x[i] <= bus.flush ? '0 : x[i-1];
            x[0]     <= bus.x_in;
            acc      <= '0;
            k        <= '0;
            in_ready <= 1'b0;
            state    <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          k   <= k + 1'b1;
          if (k == KW'(TAPS - 1)) begin
            y       <= y_conv;
            out_vld <= 1'b1;
            state   <= OUT;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_vld  <= 1'b0;
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mac_seq.sv
// tb_fir_mac_seq: directed, table-driven self-checking bench for fir_mac_seq
module tb_fir_mac_seq;
  localparam int TAPS = 4;
`ifdef FIR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct {
    longint x;
    longint y;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  vec_t tv [10];
  fir_mac_seq_if bus ();
  fir_mac_seq_if #(.OUT_W(16)) bus16 ();
  fir_mac_seq u_dut (.clk(clk), .reset(reset), .bus(bus));
  fir_mac_seq #(.OUT_W(16)) u_dut16 (.clk(clk), .reset(reset), .bus(bus16));
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", longint'(bus.in_ready), 1);
  endtask

  task automatic write_coef(input int a, input longint v);
    bus.coef_wr    = 1'b1;
    bus.coef_addr  = 2'(a);
    bus.coef_wdata = v[16:0];
    @(posedge clk); #1;
    bus.coef_wr = 1'b0;
  endtask

  task automatic do_flush();
    wait_ready();
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
  endtask

  // mode: 0 plain, 1 flush held through MAC, 2 flush with accept,
  // 3 coef write issued in MAC cycle k=1, 4 coef write issued in MAC cycle k=3
  task automatic run_sample(input longint xv, input longint exp, input int hold, input int mode);
    wait_ready();
    bus.x_in        = xv[16:0];
    bus.in_data_vld = 1'b1;
    bus.flush       = (mode == 2);
    @(posedge clk); #1;
    bus.in_data_vld = 1'b0;
    bus.flush       = (mode == 1);
    for (int i = 1; i < TAPS; i++) begin
      @(posedge clk); #1;
      chk("lat_early", longint'(bus.out_data_vld), 0);
      bus.coef_wr = (mode == 3 && i == 1) || (mode == 4 && i == 3);
    end
    @(posedge clk); #1;
    bus.coef_wr = 1'b0;
    bus.flush   = 1'b0;
    chk("lat_vld", longint'(bus.out_data_vld), 1);
    chk("y_out", longint'($signed(bus.y_out)), exp);
    if (hold > 0) begin
      bus.out_ready = 1'b0;
      repeat (hold) begin
        @(posedge clk); #1;
        chk("hold_y", longint'($signed(bus.y_out)), exp);
        chk("hold_vld", longint'(bus.out_data_vld), 1);
        chk("hold_in_ready", longint'(bus.in_ready), 0);
      end
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("vld_drop", longint'(bus.out_data_vld), 0);
  endtask

  initial begin
    tv[0] = '{3, 0};  tv[1] = '{2, 3};  tv[2] = '{1, 8};  tv[3] = '{0, 14};
    tv[4] = '{1, 8};  tv[5] = '{2, 4};  tv[6] = '{3, 4};  tv[7] = '{0, 10};
    tv[8] = '{0, 12}; tv[9] = '{0, 9};
    bus.x_in = '0; bus.in_data_vld = 1'b0; bus.flush = 1'b0; bus.coef_wr = 1'b0;
    bus.coef_addr = '0; bus.coef_wdata = '0; bus.out_ready = 1'b1;
    bus16.x_in = '0; bus16.in_data_vld = 1'b0; bus16.flush = 1'b0; bus16.coef_wr = 1'b0;
    bus16.coef_addr = '0; bus16.coef_wdata = '0; bus16.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", longint'(bus.in_ready), 0);
    chk("rst_out_vld", longint'(bus.out_data_vld), 0);
    chk("rst_y_out", longint'(bus.y_out), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_release_in_ready", longint'(bus.in_ready), 1);
    // basic filtering with c = {0,1,2,3}
    for (int i = 0; i < TAPS; i++) write_coef(i, i);
    for (int i = 0; i < 10; i++) run_sample(tv[i].x, tv[i].y, 0, 0);
    // backpressure, c = {1,1,1,1}
    for (int i = 0; i < TAPS; i++) write_coef(i, 1);
    do_flush();
    for (int i = 1; i <= 4; i++) run_sample(-1, -i, 5, 0);
    // flush in IDLE, flush coinciding with accept, flush ignored during MAC
    do_flush();
    run_sample(5, 5, 0, 0);
    run_sample(5, 10, 0, 0);
    do_flush();
    run_sample(2, 2, 0, 0);
    run_sample(3, 5, 0, 1);
    run_sample(7, 7, 0, 2);
    // coefficient write during MAC
    do_flush();
    run_sample(1, 1, 0, 0);
    run_sample(1, 2, 0, 0);
    run_sample(1, 3, 0, 0);
    bus.coef_addr = 2'd3; bus.coef_wdata = 17'd10;
    run_sample(1, 13, 0, 3);
    write_coef(3, 1);
    bus.coef_addr = 2'd3; bus.coef_wdata = 17'd10;
    run_sample(1, 4, 0, 4);
    run_sample(1, 13, 0, 0);
    // 16-bit output: wrap or saturate
    for (int a = 0; a < TAPS; a++) begin
      bus16.coef_wr = 1'b1; bus16.coef_addr = 2'(a); bus16.coef_wdata = 17'd65535;
      @(posedge clk); #1;
    end
    bus16.coef_wr = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      int n = 0;
      while (!bus16.in_ready && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("w16_in_ready", longint'(bus16.in_ready), 1);
      bus16.x_in = 17'd65535; bus16.in_data_vld = 1'b1;
      @(posedge clk); #1;
      bus16.in_data_vld = 1'b0;
      repeat (TAPS) @(posedge clk);
      #1;
      chk("w16_vld", longint'(bus16.out_data_vld), 1);
      chk("w16_y", longint'($signed(bus16.y_out)), SAT ? 32767 : j);
      @(posedge clk); #1;
    end
    // asynchronous reset in the middle of MAC
    wait_ready();
    bus.x_in = 17'd9; bus.in_data_vld = 1'b1;
    @(posedge clk); #1;
    bus.in_data_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_vld", longint'(bus.out_data_vld), 0);
    chk("mid_rst_in_ready", longint'(bus.in_ready), 0);
    chk("mid_rst_y", longint'(bus.y_out), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_release", longint'(bus.in_ready), 1);
    run_sample(7, 0, 0, 0);
    run_sample(-3, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fir_mac_seq.md
Name: fir_mac_seq

Overview:
- Parametrised, time-multiplexed successor to the fixed 4-tap parallel FIR.
- Uses one signed multiply-accumulate unit that steps over TAPS coefficients per accepted sample.
- Coefficients are run-time programmable through a write port.
- Input and output both use valid/ready handshakes, so the block drops into streaming datapaths with backpressure.

Parameters:
- DATA_W, 17, sample width (two's complement).
- COEF_W, 17, coefficient width (two's complement).
- TAPS, 4, number of taps; legal range 2..64.
- OUT_W, 36, y_out width.
- Internal accumulator width is ACC_W = DATA_W+COEF_W+$clog2(TAPS), which is 36 at defaults.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- x_in  in  DATA_W  input sample
- in_data_vld  in  1  x_in valid
- in_ready  out  1  block can accept a sample
- flush  in  1  synchronous clear of the delay line
- coef_wr  in  1  coefficient write strobe
- coef_addr  in  $clog2(TAPS)  tap index to write
- coef_wdata  in  COEF_W  coefficient value
- y_out  out  OUT_W  filter output
- out_data_vld  out  1  y_out valid
- out_ready  in  1  downstream accepts y_out

Behaviour:
- Reset: asynchronous, active-high. While asserted:
  - All delay-line registers, all coefficients and the accumulator go to 0.
  - FSM goes to IDLE; in_ready=0, out_data_vld=0, y_out=0.
  - in_ready rises on the first clk edge after reset deasserts.
- FSM states IDLE, MAC, OUT:
  - IDLE: in_ready=1. On in_data_vld&in_ready, shift the delay line (x[k]<=x[k-1], x[0]<=x_in), clear acc, k<=0, go to MAC.
  - MAC: in_ready=0. Each cycle acc<=acc+c[k]*x[k], k<=k+1. After the k=TAPS-1 cycle, register the result into y_out and go to OUT. MAC lasts exactly TAPS cycles.
  - OUT: out_data_vld=1, y_out stable. On out_ready go to IDLE, with out_data_vld low the next cycle. Without out_ready, hold OUT indefinitely with no change to y_out.
- Latency and throughput:
  - Sample accepted at edge N gives out_data_vld=1 after edge N+TAPS.
  - With out_ready tied high, minimum sample spacing is TAPS+2 cycles.
- Arithmetic:
  - Signed products are sign-extended to ACC_W; acc cannot overflow.
  - Output conversion from ACC_W to OUT_W: sign-extend if OUT_W>=ACC_W; otherwise take the low OUT_W bits (wrap), unless FIR_SAT_EN is defined.
- Coefficient writes:
  - Accepted in any state; c[coef_addr]<=coef_wdata at the edge.
  - A write during MAC to a tap not yet consumed affects the current result. A write to an already consumed tap affects the next sample only.
  - coef_addr>=TAPS is ignored.
- flush:
  - Honoured only in IDLE: clears all x[k] to 0. Coefficients are untouched.
  - If flush and an accepted sample coincide, clear first, then x[0]<=x_in.
  - flush in MAC or OUT is ignored.
- Delay-line start-up: the delay line starts at zero, so the first TAPS-1 outputs are partial sums. No discard logic.
- in_data_vld while in_ready=0 is ignored; upstream must hold the sample.

Optional Feature:
- Macro: FIR_SAT_EN.
- Defined, with OUT_W<ACC_W: y_out saturates to the signed OUT_W range, i.e. max 2^(OUT_W-1)-1 and min -2^(OUT_W-1).
- Undefined: low-bit truncation (wrap) as above.
- No effect when OUT_W>=ACC_W.

Test Plan:
- Defaults, c={0,1,2,3}, feed x=3,2,1,0,1,2,3 then 0,0,0, out_ready=1 -> y_out sequence 0,3,8,14,8,4,4,10,12,9; each out_data_vld exactly TAPS cycles after acceptance.
- Backpressure: c={1,1,1,1}, x=-1 four times, out_ready low 5 cycles per result -> y_out -1,-2,-3,-4 held stable; in_ready=0 throughout OUT.
- Flush: after x=5,5 with c={1,1,1,1}, pulse flush in IDLE, then x=2 -> y_out=2. flush during MAC has no effect.
- Coefficient write during MAC: write c[3]=10 at the MAC cycle k=1, x history {1,1,1,1} with c={1,1,1,1} -> y_out=13. Same write issued at k=3 completes -> y_out=4 now, 13 next sample.
- Reset mid-MAC: assert reset at MAC cycle 2 -> out_data_vld=0, in_ready=0 immediately. After release, c all 0 and any input gives y_out=0.
- FIR_SAT_EN with OUT_W=16: c={65535,65535,65535,65535}, x=65535 x4 -> y_out=32767. Without the macro -> low 16 bits of 4*65535^2, i.e. y_out=4.
